tx_gearbox_12to8: RTL and testbench



---
 rtl/tx_gearbox_12to8.sv | 140 ++++++++++++++
 tb/tb_tx_gearbox_12to8.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_gearbox_12to8.sv
`timescale 1ns/1ps
// tx_gearbox_12to8
//
// Pops IN_WIDTH-bit words from the TX clock-crossing FIFO read port and repacks
// them LSB-first into a continuous OUT_WIDTH-bit stream for the SerDes. Streaming
// only starts (or restarts after an underrun) once PREFILL bits are buffered, so
// the line never carries a partial word.
//
// Ports:
//   clk          FIFO read clock (the only clock)
//   reset        asynchronous reset, active-high
//   in_enable    global enable; low freezes every register
//   idle_rd      to FIFO: one word can be accepted this cycle (registers only)
//   en_rd        FIFO pop strobe, data_rd valid in the same cycle
//   data_rd      popped word
//   tx_data      registered SerDes word
//   tx_valid     registered; tx_data carries stream bits
//   underrun_cnt saturating count of underrun events
//   ovf_err      sticky: en_rd seen while idle_rd was low
module tx_gearbox_12to8 #(
    parameter int unsigned IN_WIDTH  = 12,
    parameter int unsigned OUT_WIDTH = 8,
    parameter int unsigned PREFILL   = 16,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_enable,
    output logic                 idle_rd,
    input  logic                 en_rd,
    input  logic [IN_WIDTH-1:0]  data_rd,
    output logic [OUT_WIDTH-1:0] tx_data,
    output logic                 tx_valid,
    output logic [CNT_WIDTH-1:0] underrun_cnt,
    output logic                 ovf_err
);

    localparam int unsigned BufWidth  = 2 * IN_WIDTH;
    localparam int unsigned FillWidth = $clog2(BufWidth + 1);

    localparam logic [FillWidth-1:0] InW  = FillWidth'(IN_WIDTH);
    localparam logic [FillWidth-1:0] OutW = FillWidth'(OUT_WIDTH);
    localparam logic [FillWidth-1:0] PreW = FillWidth'(PREFILL);

    typedef enum logic {
        StPrefill = 1'b0,
        StRun     = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [BufWidth-1:0]    buf_q, buf_d;
    logic [FillWidth-1:0]   fill_q, fill_d;
    logic [OUT_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;

    logic                   acc;
    logic                   emit;
    logic [BufWidth-1:0]    base_buf;
    logic [FillWidth-1:0]   base_fill;

    // Buffer datapath: shift out on emit first, then append the accepted word at
    // the (possibly reduced) fill position. Bits above fill are always zero, so a
    // plain OR is enough to append.
    always_comb begin
        idle_rd   = in_enable & (fill_q <= InW);
        acc       = en_rd & idle_rd;
        emit      = in_enable & (state_q == StRun) & (fill_q >= OutW);
        base_buf  = emit ? (buf_q >> OUT_WIDTH) : buf_q;
        base_fill = emit ? (fill_q - OutW) : fill_q;
        buf_d     = base_buf;
        fill_d    = base_fill;
        if (acc) begin
            buf_d  = base_buf | (BufWidth'(data_rd) << base_fill);
            fill_d = base_fill + InW;
        end
    end

    // Stream FSM and output registers, decided on current-cycle register values.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        cnt_d      = cnt_q;
        // A pop against a full buffer is dropped and flagged.
        ovf_d      = ovf_q | (in_enable & en_rd & ~idle_rd);
        if (in_enable) begin
            unique case (state_q)
                StPrefill: begin
                    tx_valid_d = 1'b0;
                    tx_data_d  = '0;
                    if (fill_q >= PreW) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (emit) begin
                        tx_data_d  = buf_q[OUT_WIDTH-1:0];
                        tx_valid_d = 1'b1;
                    end else begin
                        // Underrun: residual bits stay buffered for the restart.
                        tx_data_d  = '0;
                        tx_valid_d = 1'b0;
                        state_d    = StPrefill;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StPrefill;
            buf_q      <= '0;
            fill_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            fill_q     <= fill_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign underrun_cnt = cnt_q;
    assign ovf_err      = ovf_q;

endmodule

// File: tb/tb_tx_gearbox_12to8.sv
`timescale 1ns/1ps
// Testbench for tx_gearbox_12to8: directed scenarios with a bit-queue
// scoreboard for the repacked stream. A second instance with a 2-bit
// underrun counter covers saturation.
module tb_tx_gearbox_12to8;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_enable;
    logic        idle_rd;
    logic        en_rd;
    logic [11:0] data_rd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [7:0]  underrun_cnt;
    logic        ovf_err;

    logic        in_enable2;
    logic        idle_rd2;
    logic        en_rd2;
    logic [11:0] data_rd2;
    logic [7:0]  tx_data2;
    logic        tx_valid2;
    logic [1:0]  underrun_cnt2;
    logic        ovf_err2;

    int          checks = 0;
    int          errors = 0;
    bit          q[$];
    logic [11:0] next_word;
    int          pops;
    int          valid_cnt;
    logic [7:0]  last_exp;
    logic [7:0]  pre_exp [3];

    tx_gearbox_12to8 dut (
        .clk          (clk),
        .reset        (reset),
        .in_enable    (in_enable),
        .idle_rd      (idle_rd),
        .en_rd        (en_rd),
        .data_rd      (data_rd),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .underrun_cnt (underrun_cnt),
        .ovf_err      (ovf_err)
    );

    tx_gearbox_12to8 #(.CNT_WIDTH(2)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .in_enable    (in_enable2),
        .idle_rd      (idle_rd2),
        .en_rd        (en_rd2),
        .data_rd      (data_rd2),
        .tx_data      (tx_data2),
        .tx_valid     (tx_valid2),
        .underrun_cnt (underrun_cnt2),
        .ovf_err      (ovf_err2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // FIFO model plus scoreboard: pops whenever idle_rd allows (if feeding) and
    // checks every valid output byte against the oldest queued bits.
    task automatic run_cycles(input int n, input bit feed);
        logic        pend;
        logic [11:0] word;
        logic [7:0]  exp;
        for (int c = 0; c < n; c++) begin
            en_rd   = feed & idle_rd;
            word    = next_word;
            data_rd = word;
            pend    = en_rd;
            tick();
            en_rd = 1'b0;
            if (pend) begin
                for (int b = 0; b < 12; b++) q.push_back(word[b]);
                next_word++;
                pops++;
            end
            if (tx_valid === 1'b1) begin
                valid_cnt++;
                checks++;
                if (q.size() < 8) begin
                    errors++;
                    $display("FAIL stream_underflow: tx_data=%h with only %0d model bits",
                             tx_data, q.size());
                end else begin
                    exp = '0;
                    for (int b = 0; b < 8; b++) exp[b] = q.pop_front();
                    last_exp = exp;
                    if (tx_data !== exp) begin
                        errors++;
                        $display("FAIL stream_data: got %h expected %h", tx_data, exp);
                    end
                end
            end
        end
    endtask

    task automatic apply_reset;
        reset      = 1'b1;
        in_enable  = 1'b1;
        en_rd      = 1'b0;
        data_rd    = '0;
        in_enable2 = 1'b1;
        en_rd2     = 1'b0;
        data_rd2   = '0;
        q.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Pops 0x321 then 0xA54 into an empty PREFILL block and follows it to underrun.
    task automatic run_prefill_seq;
        en_rd   = 1'b1;
        data_rd = 12'h321;
        tick();
        checks++;
        if (dut.fill_q !== 5'd12 || idle_rd !== 1'b1 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL prefill_first: fill=%0d idle=%b valid=%b expected 12/1/0",
                     dut.fill_q, idle_rd, tx_valid);
        end
        data_rd = 12'hA54;
        tick();
        en_rd = 1'b0;
        checks++;
        if (dut.fill_q !== 5'd24 || idle_rd !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL prefill_full: fill=%0d idle=%b valid=%b expected 24/0/0",
                     dut.fill_q, idle_rd, tx_valid);
        end
        tick();
        checks++;
        if (dut.state_q !== 1'b1 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL prefill_enter_run: state=%0d valid=%b expected 1/0",
                     dut.state_q, tx_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== pre_exp[i]) begin
                errors++;
                $display("FAIL prefill_byte%0d: valid=%b data=%h expected 1/%h",
                         i, tx_valid, tx_data, pre_exp[i]);
            end
        end
        tick();
        checks++;
        if (tx_valid !== 1'b0 || underrun_cnt !== 8'd1 || dut.state_q !== 1'b0 ||
            dut.fill_q !== 5'd0) begin
            errors++;
            $display("FAIL prefill_drain: valid=%b cnt=%0d state=%0d fill=%0d expected 0/1/0/0",
                     tx_valid, underrun_cnt, dut.state_q, dut.fill_q);
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        in_enable = 1'b1;
        in_enable2 = 1'b1;
        en_rd     = 1'b0;
        en_rd2    = 1'b0;
        data_rd   = '0;
        data_rd2  = '0;
        #3;
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || underrun_cnt !== 8'd0 ||
            ovf_err !== 1'b0 || idle_rd !== 1'b1 || dut.fill_q !== 5'd0 ||
            dut.state_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h cnt=%0d ovf=%b idle=%b fill=%0d st=%0d",
                     tx_valid, tx_data, underrun_cnt, ovf_err, idle_rd, dut.fill_q,
                     dut.state_q);
        end
        checks++;
        if (underrun_cnt2 !== 2'd0 || tx_valid2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut2: cnt=%0d valid=%b expected 0/0", underrun_cnt2, tx_valid2);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_prefill;
        apply_reset();
        run_prefill_seq();
    endtask

    task automatic test_steady;
        int gaps;
        bit started;
        apply_reset();
        next_word = 12'h000;
        pops      = 0;
        valid_cnt = 0;
        gaps      = 0;
        started   = 1'b0;
        for (int c = 0; c < 300; c++) begin
            run_cycles(1, 1'b1);
            if (tx_valid === 1'b1) started = 1'b1;
            else if (started) gaps++;
        end
        checks++;
        if (gaps !== 0) begin
            errors++;
            $display("FAIL steady_gaps: %0d idle cycles after start, expected 0", gaps);
        end
        checks++;
        if (pops !== 199) begin
            errors++;
            $display("FAIL steady_pops: %0d pops in 300 cycles, expected 199", pops);
        end
        checks++;
        if (valid_cnt !== 297) begin
            errors++;
            $display("FAIL steady_valid: %0d valid words, expected 297", valid_cnt);
        end
        checks++;
        if (underrun_cnt !== 8'd0 || dut.fill_q !== q.size()) begin
            errors++;
            $display("FAIL steady_end: cnt=%0d fill=%0d expected 0/%0d",
                     underrun_cnt, dut.fill_q, q.size());
        end
    endtask

    task automatic test_underrun;
        bit found;
        int j;
        int hist [32];
        apply_reset();
        next_word = 12'h100;
        run_cycles(20, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            run_cycles(1, 1'b0);
            if (tx_valid === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || underrun_cnt !== 8'd1 || q.size() >= 8) begin
            errors++;
            $display("FAIL underrun_detect: found=%b cnt=%0d model_fill=%0d expected 1/1/<8",
                     found, underrun_cnt, q.size());
        end
        checks++;
        if (dut.fill_q !== q.size() || dut.state_q !== 1'b0) begin
            errors++;
            $display("FAIL underrun_residual: fill=%0d state=%0d expected %0d/0",
                     dut.fill_q, dut.state_q, q.size());
        end
        hist[0] = q.size();
        j = 0;
        for (int k = 1; k < 30; k++) begin
            run_cycles(1, 1'b1);
            hist[k] = q.size();
            if (tx_valid === 1'b1) begin
                j = k;
                break;
            end
        end
        checks++;
        if (j < 3) begin
            errors++;
            $display("FAIL underrun_restart: first valid at cycle %0d, expected >= 3", j);
        end else if (hist[j-2] < 16 || hist[j-3] >= 16) begin
            errors++;
            $display("FAIL underrun_restart: fill two/three cycles before=%0d/%0d expected >=16/<16",
                     hist[j-2], hist[j-3]);
        end
        run_cycles(30, 1'b1);
        checks++;
        if (underrun_cnt !== 8'd1) begin
            errors++;
            $display("FAIL underrun_count_after: cnt=%0d expected 1", underrun_cnt);
        end
    endtask

    task automatic test_saturation;
        logic [1:0] exp;
        apply_reset();
        for (int r = 0; r < 5; r++) begin
            en_rd2   = 1'b1;
            data_rd2 = 12'h0F0;
            tick();
            data_rd2 = 12'h00F;
            tick();
            en_rd2 = 1'b0;
            repeat (5) tick();
            exp = (r < 2) ? 2'(r + 1) : 2'd3;
            checks++;
            if (underrun_cnt2 !== exp || tx_valid2 !== 1'b0) begin
                errors++;
                $display("FAIL sat_round%0d: cnt=%0d valid=%b expected %0d/0",
                         r, underrun_cnt2, tx_valid2, exp);
            end
        end
        checks++;
        if (ovf_err2 !== 1'b0) begin
            errors++;
            $display("FAIL sat_ovf: ovf=%b expected 0", ovf_err2);
        end
    endtask

    task automatic test_freeze;
        int snap;
        apply_reset();
        next_word = 12'h200;
        run_cycles(25, 1'b1);
        in_enable = 1'b0;
        // Strobe a pop while frozen: it must be ignored without flagging an error.
        en_rd     = 1'b1;
        data_rd   = 12'hFFF;
        snap      = q.size();
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (idle_rd !== 1'b0 || tx_valid !== 1'b1 || tx_data !== last_exp ||
                dut.fill_q !== snap) begin
                errors++;
                $display("FAIL freeze_hold%0d: idle=%b valid=%b data=%h fill=%0d expected 0/1/%h/%0d",
                         c, idle_rd, tx_valid, tx_data, dut.fill_q, last_exp, snap);
            end
        end
        checks++;
        if (ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL freeze_ovf: ovf=%b expected 0", ovf_err);
        end
        en_rd     = 1'b0;
        in_enable = 1'b1;
        run_cycles(15, 1'b1);
    endtask

    task automatic test_ovf;
        bit         found;
        int         snap;
        logic [7:0] exp;
        found = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (idle_rd === 1'b0) begin
                found = 1'b1;
                break;
            end
            run_cycles(1, 1'b1);
        end
        checks++;
        if (!found || ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_setup: found_full=%b ovf=%b expected 1/0", found, ovf_err);
        end
        snap    = q.size();
        en_rd   = 1'b1;
        data_rd = 12'hFFF;
        tick();
        en_rd = 1'b0;
        checks++;
        if (tx_valid !== 1'b1 || q.size() < 8) begin
            errors++;
            $display("FAIL ovf_emit: valid=%b model_fill=%0d expected 1/>=8", tx_valid, q.size());
        end else begin
            exp = '0;
            for (int b = 0; b < 8; b++) exp[b] = q.pop_front();
            if (tx_data !== exp) begin
                errors++;
                $display("FAIL ovf_emit: data=%h expected %h", tx_data, exp);
            end
        end
        checks++;
        if (ovf_err !== 1'b1 || dut.fill_q !== snap - 8) begin
            errors++;
            $display("FAIL ovf_flag: ovf=%b fill=%0d expected 1/%0d", ovf_err, dut.fill_q,
                     snap - 8);
        end
        run_cycles(20, 1'b1);
        checks++;
        if (ovf_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: ovf=%b expected 1", ovf_err);
        end
    endtask

    task automatic test_async_reset;
        run_cycles(5, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || dut.fill_q !== 5'd0 ||
            dut.state_q !== 1'b0 || ovf_err !== 1'b0 || underrun_cnt !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%b data=%h fill=%0d state=%0d ovf=%b cnt=%0d",
                     tx_valid, tx_data, dut.fill_q, dut.state_q, ovf_err, underrun_cnt);
        end
        en_rd = 1'b0;
        q.delete();
        #2;
        reset = 1'b0;
        run_prefill_seq();
    endtask

    initial begin
        pre_exp[0] = 8'h21;
        pre_exp[1] = 8'h43;
        pre_exp[2] = 8'hA5;
        next_word  = '0;
        pops       = 0;
        valid_cnt  = 0;
        last_exp   = '0;
        test_reset();
        test_prefill();
        test_steady();
        test_underrun();
        test_saturation();
        test_freeze();
        test_ovf();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
